// File: rtl/vga_fb_pkg.sv
// Shared constants, bus FSM encoding and pixel format helper for the
// double-buffered VGA framebuffer arbiter.
package vga_fb_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int FB_PIXELS    = 307200;

  typedef enum logic [1:0] {
    BUS_IDLE  = 2'd0,
    BUS_READ  = 2'd1,
    BUS_WRITE = 2'd2
  } bus_state_e;

  // MSB replication keeps full-scale 565 components at full-scale 888.
  function automatic logic [23:0] rgb565_to_888(input logic [15:0] c);
    return {c[15:11], c[15:13], c[10:5], c[10:9], c[4:0], c[4:2]};
  endfunction

endpackage

// File: rtl/fb_wr_hold.sv
// One-entry write holding register; out-of-range addresses are accepted
// but dropped so they never reach the SRAM.
module fb_wr_hold
  import vga_fb_pkg::*;
#(
  parameter int DEPTH = FB_PIXELS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [18:0] in_addr,
  input  logic [15:0] in_data,
  input  logic        issue,
  output logic        full,
  output logic [18:0] addr,
  output logic [15:0] data
);

  localparam logic [19:0] LIMIT = 20'(DEPTH);

  logic        full_d, full_q;
  logic [18:0] addr_d, addr_q;
  logic [15:0] data_d, data_q;
  logic        accept;

  always_comb begin
    accept = in_valid && !full_q;
    full_d = full_q;
    addr_d = addr_q;
    data_d = data_q;
    if (issue) full_d = 1'b0;
    if (accept && ({1'b0, in_addr} < LIMIT)) begin
      full_d = 1'b1;
      addr_d = in_addr;
      data_d = in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign in_ready = !full_q;
  assign full     = full_q;
  assign addr     = addr_q;
  assign data     = data_q;

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port SRAM arbiter: display reads take strict priority over queued
// framebuffer writes; writes target the back bank, reads the front bank.
module vga_fb_arbiter
  import vga_fb_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic        pix_en,
  input  logic        pix_act,
  output logic [23:0] pix_rgb,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [18:0] wr_addr,
  input  logic [15:0] wr_data,
  input  logic        swap_req,
  input  logic        frame_end,
  output logic        swap_done,
  output logic        front,
  output logic [19:0] sram_addr,
  output logic [15:0] sram_dq_o,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_i,
  output logic        sram_we_n,
  output logic        sram_oe_n
);

  bus_state_e  state_d, state_q;
  logic [19:0] addr_d, addr_q;
  logic [15:0] dq_o_d, dq_o_q;
  logic        oe_n_d, oe_n_q, we_n_d, we_n_q, dq_oe_d, dq_oe_q;
  logic [23:0] rgb_d, rgb_q;
  logic        blank_d, blank_q;
  logic        front_d, front_q, pend_d, pend_q, swap_done_d, swap_done_q;
  logic        read_go, write_go, toggle;
  logic        hold_full;
  logic [18:0] hold_addr, lin_addr;
  logic [15:0] hold_data;

  fb_wr_hold #(.DEPTH(H_ACTIVE * V_ACTIVE)) u_hold (
    .clk      (clk),
    .rst      (rst),
    .in_valid (wr_valid),
    .in_ready (wr_ready),
    .in_addr  (wr_addr),
    .in_data  (wr_data),
    .issue    (write_go),
    .full     (hold_full),
    .addr     (hold_addr),
    .data     (hold_data)
  );

  always_comb begin
    lin_addr = 19'(pix_y) * 19'(H_ACTIVE) + 19'(pix_x);
    read_go  = pix_en && pix_act;
    write_go = hold_full && !read_go;
    state_d  = BUS_IDLE;
    addr_d   = addr_q;
    dq_o_d   = dq_o_q;
    oe_n_d   = 1'b1;
    we_n_d   = 1'b1;
    dq_oe_d  = 1'b0;
    if (read_go) begin
      state_d = BUS_READ;
      addr_d  = {front_q, lin_addr};
      oe_n_d  = 1'b0;
    end else if (write_go) begin
      state_d = BUS_WRITE;
      addr_d  = {~front_q, hold_addr};
      dq_o_d  = hold_data;
      we_n_d  = 1'b0;
      dq_oe_d = 1'b1;
    end

    // Display pipeline: capture at end of READ, or blank for inactive strobes.
    blank_d = pix_en && !pix_act;
    rgb_d   = rgb_q;
    if (state_q == BUS_READ) rgb_d = rgb565_to_888(sram_dq_i);
    else if (blank_q)        rgb_d = '0;

    toggle      = frame_end && (pend_q || swap_req);
    pend_d      = (pend_q || swap_req) && !toggle;
    front_d     = front_q ^ toggle;
    swap_done_d = toggle;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= BUS_IDLE;
      addr_q      <= '0;
      dq_o_q      <= '0;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      dq_oe_q     <= 1'b0;
      rgb_q       <= '0;
      blank_q     <= 1'b0;
      front_q     <= 1'b0;
      pend_q      <= 1'b0;
      swap_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      dq_o_q      <= dq_o_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      dq_oe_q     <= dq_oe_d;
      rgb_q       <= rgb_d;
      blank_q     <= blank_d;
      front_q     <= front_d;
      pend_q      <= pend_d;
      swap_done_q <= swap_done_d;
    end
  end

  assign sram_addr  = addr_q;
  assign sram_dq_o  = dq_o_q;
  assign sram_oe_n  = oe_n_q;
  assign sram_we_n  = we_n_q;
  assign sram_dq_oe = dq_oe_q;
  assign pix_rgb    = rgb_q;
  assign front      = front_q;
  assign swap_done  = swap_done_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter: a cycle table plus hand sequences for
// swap handling and reset during a write.
module tb_vga_fb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  pix_x, pix_y;
  logic        pix_en, pix_act;
  logic [23:0] pix_rgb;
  logic        wr_valid, wr_ready;
  logic [18:0] wr_addr;
  logic [15:0] wr_data;
  logic        swap_req, frame_end, swap_done, front;
  logic [19:0] sram_addr;
  logic [15:0] sram_dq_o, sram_dq_i;
  logic        sram_dq_oe, sram_we_n, sram_oe_n;

  int checks = 0;
  int errors = 0;

  vga_fb_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_en     (pix_en),
    .pix_act    (pix_act),
    .pix_rgb    (pix_rgb),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .swap_req   (swap_req),
    .frame_end  (frame_end),
    .swap_done  (swap_done),
    .front      (front),
    .sram_addr  (sram_addr),
    .sram_dq_o  (sram_dq_o),
    .sram_dq_oe (sram_dq_oe),
    .sram_dq_i  (sram_dq_i),
    .sram_we_n  (sram_we_n),
    .sram_oe_n  (sram_oe_n)
  );

  always #5 clk = ~clk;

  // Inputs of a record are applied for one cycle; expected values are the
  // outputs seen at the start of that same record (result of the prior edge).
  typedef struct packed {
    logic        pen, pact;
    logic [9:0]  px, py;
    logic        wv;
    logic [18:0] wa;
    logic [15:0] wd;
    logic        sreq, fend;
    logic [15:0] dq;
    logic        eoe_n, ewe_n, edq_oe;
    logic [19:0] eaddr;
    logic [15:0] edq_o;
    logic [23:0] ergb;
    logic        erdy, efront, eswap;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic clear_inputs();
    pix_en = 0; pix_act = 0; pix_x = 0; pix_y = 0;
    wr_valid = 0; wr_addr = 0; wr_data = 0;
    swap_req = 0; frame_end = 0; sram_dq_i = 0;
  endtask

  task automatic check_reset_values(input int tag);
    chk("rst_we_n", tag, 32'(sram_we_n), 32'd1);
    chk("rst_oe_n", tag, 32'(sram_oe_n), 32'd1);
    chk("rst_dq_oe", tag, 32'(sram_dq_oe), 32'd0);
    chk("rst_addr", tag, 32'(sram_addr), 32'd0);
    chk("rst_dq_o", tag, 32'(sram_dq_o), 32'd0);
    chk("rst_rgb", tag, 32'(pix_rgb), 32'd0);
    chk("rst_ready", tag, 32'(wr_ready), 32'd1);
    chk("rst_front", tag, 32'(front), 32'd0);
    chk("rst_swap_done", tag, 32'(swap_done), 32'd0);
  endtask

  task automatic wr_vec(input int i, input logic [18:0] a, input logic [15:0] d);
    vecs[i].wv = 1; vecs[i].wa = a; vecs[i].wd = d;
  endtask

  task automatic pix_vec(input int i, input logic act, input logic [9:0] x, input logic [9:0] y);
    vecs[i].pen = 1; vecs[i].pact = act; vecs[i].px = x; vecs[i].py = y;
  endtask

  task automatic exp_read(input int i, input logic [19:0] a);
    vecs[i].eoe_n = 0; vecs[i].eaddr = a;
  endtask

  task automatic exp_write(input int i, input logic [19:0] a, input logic [15:0] d);
    vecs[i].ewe_n = 0; vecs[i].edq_oe = 1; vecs[i].eaddr = a; vecs[i].edq_o = d;
  endtask

  initial begin
    int seen;
    for (int i = 0; i < NV; i++) begin
      vecs[i] = '0;
      vecs[i].eoe_n = 1; vecs[i].ewe_n = 1; vecs[i].erdy = 1;
    end
    // Read at (3,2) from bank 0, then a write to back bank 1.
    pix_vec(0, 1, 10'd3, 10'd2);
    exp_read(1, 20'h00503); vecs[1].dq = 16'hF800;
    vecs[2].ergb = 24'hFF0000; wr_vec(2, 19'd10, 16'h07E0);
    vecs[3].ergb = 24'hFF0000; vecs[3].erdy = 0;
    vecs[4].ergb = 24'hFF0000; exp_write(4, 20'h8000A, 16'h07E0);
    // Held write collides with a read and is deferred one cycle.
    vecs[5].ergb = 24'hFF0000; wr_vec(5, 19'd5, 16'h001F);
    vecs[6].ergb = 24'hFF0000; vecs[6].erdy = 0; pix_vec(6, 1, 10'd0, 10'd1);
    vecs[7].ergb = 24'hFF0000; vecs[7].erdy = 0; exp_read(7, 20'h00280); vecs[7].dq = 16'h07E0;
    vecs[8].ergb = 24'h00FF00; exp_write(8, 20'h80005, 16'h001F);
    // Out-of-range write is dropped; inactive strobe blanks the pixel.
    wr_vec(8, 19'd307200, 16'hFFFF);
    vecs[9].ergb = 24'h00FF00; pix_vec(9, 0, 10'd5, 10'd5);
    vecs[10].ergb = 24'h00FF00;
    vecs[11].sreq = 1; vecs[11].fend = 1;
    vecs[12].efront = 1; vecs[12].eswap = 1; wr_vec(12, 19'd1, 16'h1234);
    vecs[13].efront = 1; vecs[13].erdy = 0; vecs[13].fend = 1;
    vecs[14].efront = 1; exp_write(14, 20'h00001, 16'h1234); vecs[14].sreq = 1;
    vecs[15].efront = 1; vecs[15].fend = 1;
    vecs[16].eswap = 1; pix_vec(16, 1, 10'd639, 10'd479);
    exp_read(17, 20'h4AFFF); vecs[17].dq = 16'h1234;
    vecs[18].ergb = 24'h1045A5;

    clear_inputs();
    rst = 1;
    repeat (3) @(negedge clk);
    check_reset_values(-1);
    rst = 0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      chk("oe_n", i, 32'(sram_oe_n), 32'(vecs[i].eoe_n));
      chk("we_n", i, 32'(sram_we_n), 32'(vecs[i].ewe_n));
      chk("dq_oe", i, 32'(sram_dq_oe), 32'(vecs[i].edq_oe));
      if (!vecs[i].eoe_n || !vecs[i].ewe_n) chk("addr", i, 32'(sram_addr), 32'(vecs[i].eaddr));
      if (!vecs[i].ewe_n) chk("dq_o", i, 32'(sram_dq_o), 32'(vecs[i].edq_o));
      chk("pix_rgb", i, 32'(pix_rgb), 32'(vecs[i].ergb));
      chk("wr_ready", i, 32'(wr_ready), 32'(vecs[i].erdy));
      chk("front", i, 32'(front), 32'(vecs[i].efront));
      chk("swap_done", i, 32'(swap_done), 32'(vecs[i].eswap));
      pix_en = vecs[i].pen; pix_act = vecs[i].pact; pix_x = vecs[i].px; pix_y = vecs[i].py;
      wr_valid = vecs[i].wv; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
      swap_req = vecs[i].sreq; frame_end = vecs[i].fend; sram_dq_i = vecs[i].dq;
    end

    // Repeated swap requests collapse into a single toggle.
    @(negedge clk); clear_inputs(); swap_req = 1;
    @(negedge clk); swap_req = 1;
    @(negedge clk); swap_req = 0; frame_end = 1;
    @(negedge clk); frame_end = 1;
    chk("multi_swap_front", 100, 32'(front), 32'd1);
    chk("multi_swap_done", 100, 32'(swap_done), 32'd1);
    @(negedge clk); frame_end = 0;
    chk("second_fend_front", 101, 32'(front), 32'd1);
    chk("second_fend_done", 101, 32'(swap_done), 32'd0);

    // Reset asserted in the middle of a WRITE cycle.
    wr_valid = 1; wr_addr = 19'd7; wr_data = 16'hABCD;
    @(negedge clk); clear_inputs();
    seen = 0;
    for (int c = 0; c < 6 && !seen; c++) begin
      @(negedge clk);
      if (sram_we_n == 1'b0) seen = 1;
    end
    chk("write_seen", 102, 32'(seen), 32'd1);
    chk("write_addr_bank0", 102, 32'(sram_addr), 32'h00007);
    #2 rst = 1;
    #1;
    check_reset_values(103);
    @(negedge clk); rst = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("post_rst_we_n", 104 + c, 32'(sram_we_n), 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
